// File: rtl/kpscan_if.sv
// Keypad pin and key-event bundle between the scan controller and its surroundings.
// master: the scan controller; slave: the keypad pins / application side.
interface kpscan_if;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    input  kpr,
    output kpc, key_code, key_valid, key_down
  );

  modport slave (
    output kpr,
    input  kpc, key_code, key_valid, key_down
  );
endinterface

// File: rtl/kpscan.sv
// 4x4 keypad scanner: rotates a low column, debounces press and release of a
// single key and reports it as a one-cycle event with a 4-bit code.
//
// state       | meaning
// ST_SCAN     | rotating columns, sampling rows at each column's terminal count
// ST_DEBOUNCE | one row low on the held column, waiting for DB_CYCLES stable cycles
// ST_HELD     | key accepted, column held, waiting for all rows high
// ST_RELEASE  | all rows high, waiting for DB_CYCLES stable cycles before rescanning
module kpscan #(
  parameter int SCAN_DIV  = 50000,
  parameter int DB_CYCLES = 500000
) (
  input  logic     clk,
  input  logic     reset_n,
  kpscan_if.master kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DB_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t            state_q;
  logic [3:0]        kpr_m_q;
  logic [3:0]        kpr_s_q;
  logic [3:0]        row_q;
  logic [3:0]        kpc_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic [3:0]        key_code_q;
  logic              key_valid_q;
  logic              key_down_q;

  logic [3:0]        kpc_rot_d;
  logic              kpr_one_low;
  logic [1:0]        row_idx;
  logic [1:0]        col_idx;

  assign kpc_rot_d = {kpc_q[2:0], kpc_q[3]};

  always_comb begin
    kpr_one_low = 1'b0;
    row_idx     = 2'd3;
    col_idx     = 2'd3;
    case (kpr_s_q)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: kpr_one_low = 1'b1;
      default:                            kpr_one_low = 1'b0;
    endcase
    case (row_q)
      4'b0111: row_idx = 2'd0;
      4'b1011: row_idx = 2'd1;
      4'b1101: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase
    case (kpc_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      default: col_idx = 2'd3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SCAN;
      kpr_m_q     <= 4'hF;
      kpr_s_q     <= 4'hF;
      row_q       <= 4'hF;
      kpc_q       <= 4'b1110;
      div_cnt_q   <= '0;
      db_cnt_q    <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      kpr_m_q     <= kp.kpr;
      kpr_s_q     <= kpr_m_q;
      key_valid_q <= 1'b0;
      case (state_q)
        ST_SCAN: begin
          // Rows are only trusted at the end of a column's dwell, once lines have settled.
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            if (kpr_one_low) begin
              row_q    <= kpr_s_q;
              db_cnt_q <= '0;
              state_q  <= ST_DEBOUNCE;
            end else begin
              kpc_q <= kpc_rot_d;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (kpr_s_q != row_q) begin
            div_cnt_q <= '0;
            state_q   <= ST_SCAN;
          end else if (db_cnt_q == DB_LAST) begin
            key_code_q  <= {row_idx, col_idx};
            key_valid_q <= 1'b1;
            key_down_q  <= 1'b1;
            state_q     <= ST_HELD;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (kpr_s_q == 4'hF) begin
            db_cnt_q <= '0;
            state_q  <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (kpr_s_q != 4'hF) begin
            db_cnt_q <= '0;
            state_q  <= ST_HELD;
          end else if (db_cnt_q == DB_LAST) begin
            key_down_q <= 1'b0;
            kpc_q      <= kpc_rot_d;
            div_cnt_q  <= '0;
            state_q    <= ST_SCAN;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign kp.kpc       = kpc_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_down  = key_down_q;

endmodule
